aes_stream_ctrl: RTL

- Block-level stream controller directly upstream and downstream of aes_core_gen.
- Accepts 128-bit blocks on a valid/ready input stream and launches the core with a one-cycle start.
- Applies ECB or CBC chaining, captures the core result on done, and presents it on a valid/ready output stream.
- Holds the key, mode, direction and IV configuration, and includes a watchdog on core completion.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_stream_ctrl_if.sv | 24 ++
 rtl/aes_chain_unit.sv | 51 +++++
 rtl/aes_stream_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES stream controller slice.
package aes_pkg;

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned KEY_W  = 256;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic [MODE_W-1:0] AES128 = 2'b00;
    localparam logic [MODE_W-1:0] AES192 = 2'b01;
    localparam logic [MODE_W-1:0] AES256 = 2'b10;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    // Configuration snapshot taken on an accepted cfg_load.
    typedef struct packed {
        logic [KEY_W-1:0]  key;
        logic [MODE_W-1:0] mode;
        logic              enc_dec;
        logic              cbc;
    } cfg_t;

endpackage

// File: rtl/aes_stream_ctrl_if.sv
// Input/output block streams of the AES stream controller.
interface aes_stream_ctrl_if;
    import aes_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/aes_chain_unit.sv
// CBC chaining state: chain/ct_hold/IV registers plus the pre- and post-core XORs.
module aes_chain_unit
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BLK_W-1:0] iv_in,
    input  logic             accept,
    input  logic             capture,
    input  logic             last,
    input  logic             abort,
    input  logic             enc_dec,
    input  logic             cbc,
    input  logic [BLK_W-1:0] in_data,
    input  logic [BLK_W-1:0] core_out,
    output logic [BLK_W-1:0] blk_in_c,
    output logic [BLK_W-1:0] result_c
);

    logic [BLK_W-1:0] iv_q;
    logic [BLK_W-1:0] chain_q;
    logic [BLK_W-1:0] ct_hold_q;

    assign blk_in_c = (cbc && enc_dec == ENC) ? (in_data ^ chain_q) : in_data;
    assign result_c = (cbc && enc_dec == DEC) ? (core_out ^ chain_q) : core_out;

    // End of message or an abandoned block restarts the chain from the IV.
    always_ff @(posedge clk) begin
        if (reset) begin
            iv_q      <= '0;
            chain_q   <= '0;
            ct_hold_q <= '0;
        end else begin
            if (load) begin
                iv_q    <= iv_in;
                chain_q <= iv_in;
            end else if (abort) begin
                chain_q <= iv_q;
            end else if (capture) begin
                if (last)
                    chain_q <= iv_q;
                else if (cbc)
                    chain_q <= (enc_dec == DEC) ? ct_hold_q : core_out;
            end
            if (accept && cbc && enc_dec == DEC)
                ct_hold_q <= in_data;
        end
    end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Stream controller around aes_core_gen: block handshake, core launch, chaining,
// result holding register and completion watchdog.
module aes_stream_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TW      = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_load,
    input  logic [KEY_W-1:0]  cfg_key,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic              cfg_enc_dec,
    input  logic              cfg_cbc,
    input  logic [BLK_W-1:0]  cfg_iv,
    aes_stream_ctrl_if.slave  s,
    output logic              busy,
    output logic              err,
    output logic              core_start,
    output logic              core_enc_dec,
    output logic [MODE_W-1:0] core_mode,
    output logic [KEY_W-1:0]  core_key,
    output logic [BLK_W-1:0]  core_data_in,
    input  logic [BLK_W-1:0]  core_data_out,
    input  logic              core_done
);

    // Abort on the cycle that makes err visible TIMEOUT cycles after core_start.
    localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 2);

    state_t           state;
    state_t           state_nxt;
    cfg_t             cfg_q;
    logic             cfg_ok;
    logic             last_q;
    logic [TW-1:0]    wdog;
    logic             cfg_take;
    logic             in_ready_c;
    logic             accept;
    logic             capture;
    logic             abort;
    logic             wdog_clr;
    logic             wdog_inc;
    logic [BLK_W-1:0] blk_in_c;
    logic [BLK_W-1:0] result_c;

    assign core_key     = cfg_q.key;
    assign core_mode    = cfg_q.mode;
    assign core_enc_dec = cfg_q.enc_dec;
    assign busy         = (state != IDLE) || s.out_valid;
    assign cfg_take     = cfg_load && !busy;
    assign s.in_ready   = in_ready_c;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (capture || abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A drain in the same cycle frees the output register for a new acceptance.
    always_comb begin
        in_ready_c = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        wdog_clr   = 1'b0;
        wdog_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_c = cfg_ok && (!s.out_valid || s.out_ready);
                accept     = in_ready_c && s.in_valid;
            end
            LAUNCH: wdog_clr = 1'b1;
            WAIT: begin
                wdog_inc = 1'b1;
                capture  = core_done;
                abort    = !core_done && (wdog == WDOG_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q        <= '0;
            cfg_ok       <= 1'b0;
            err          <= 1'b0;
            last_q       <= 1'b0;
            wdog         <= '0;
            core_start   <= 1'b0;
            core_data_in <= '0;
            s.out_valid  <= 1'b0;
            s.out_data   <= '0;
            s.out_last   <= 1'b0;
        end else begin
            core_start <= accept;
            if (cfg_take) begin
                cfg_q  <= '{key: cfg_key, mode: cfg_mode, enc_dec: cfg_enc_dec, cbc: cfg_cbc};
                cfg_ok <= 1'b1;
                err    <= 1'b0;
            end else if (abort) begin
                err <= 1'b1;
            end
            if (accept) begin
                core_data_in <= blk_in_c;
                last_q       <= s.in_last;
            end
            if (wdog_clr)
                wdog <= '0;
            else if (wdog_inc)
                wdog <= wdog + TW'(1);
            if (capture) begin
                s.out_valid <= 1'b1;
                s.out_data  <= result_c;
                s.out_last  <= last_q;
            end else if (s.out_valid && s.out_ready) begin
                s.out_valid <= 1'b0;
            end
        end
    end

    aes_chain_unit u_chain (
        .clk      (clk),
        .reset    (reset),
        .load     (cfg_take),
        .iv_in    (cfg_iv),
        .accept   (accept),
        .capture  (capture),
        .last     (last_q),
        .abort    (abort),
        .enc_dec  (cfg_q.enc_dec),
        .cbc      (cfg_q.cbc),
        .in_data  (s.in_data),
        .core_out (core_data_out),
        .blk_in_c (blk_in_c),
        .result_c (result_c)
    );

endmodule
